// File: rtl/bp_be_fp_iter_ctrl.sv
// Sequencer for the shared iterative FP divide/sqrt unit: resolves the rounding mode,
// launches the unit, returns a NaN-boxed result and keeps the sticky fflags accumulator.
module bp_be_fp_iter_ctrl #(
    parameter int dword_width_p    = 64,
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        req_v_i,
    output logic                        req_ready_o,
    input  logic                        req_op_i,
    input  logic                        req_dp_i,
    input  logic [2:0]                  req_rm_i,
    input  logic [dword_width_p-1:0]    req_a_i,
    input  logic [dword_width_p-1:0]    req_b_i,
    input  logic [reg_addr_width_p-1:0] req_rd_i,
    input  logic [2:0]                  frm_i,
    input  logic                        flush_i,
    output logic                        unit_v_o,
    input  logic                        unit_ready_i,
    output logic                        unit_op_o,
    output logic                        unit_dp_o,
    output logic [2:0]                  unit_rm_o,
    output logic [dword_width_p-1:0]    unit_a_o,
    output logic [dword_width_p-1:0]    unit_b_o,
    input  logic                        unit_v_i,
    input  logic [dword_width_p-1:0]    unit_data_i,
    input  logic [4:0]                  unit_fflags_i,
    output logic                        resp_v_o,
    input  logic                        resp_yumi_i,
    output logic [dword_width_p-1:0]    resp_data_o,
    output logic [reg_addr_width_p-1:0] resp_rd_o,
    output logic [4:0]                  resp_fflags_o,
    output logic                        resp_illegal_o,
    input  logic                        fflags_clr_i,
    output logic [4:0]                  fflags_acc_o
);

    typedef enum logic [2:0] {
        e_idle  = 3'd0,
        e_issue = 3'd1,
        e_wait  = 3'd2,
        e_resp  = 3'd3,
        e_drain = 3'd4
    } state_e;

    localparam logic [2:0] rm_dyn_lp = 3'b111;

    // Encodings 101..111 are reserved once e_dyn has been resolved against frm.
    function automatic logic rm_illegal(input logic [2:0] rm);
        rm_illegal = (rm >= 3'b101);
    endfunction

    state_e                      state_q, state_d;
    logic                        op_q, op_d, dp_q, dp_d, illegal_q, illegal_d;
    logic [2:0]                  rm_q, rm_d, rm_res_s;
    logic [dword_width_p-1:0]    a_q, a_d, b_q, b_d, data_q, data_d;
    logic [reg_addr_width_p-1:0] rd_q, rd_d;
    logic [4:0]                  fflags_q, fflags_d, acc_q, acc_d;
    logic                        accum_s;

    assign rm_res_s = (req_rm_i == rm_dyn_lp) ? frm_i : req_rm_i;
    assign accum_s  = (state_q == e_resp) & resp_yumi_i & ~flush_i & ~illegal_q;

    // Next-state, operand capture and result capture.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dp_d      = dp_q;
        rm_d      = rm_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        data_d    = data_q;
        fflags_d  = fflags_q;
        illegal_d = illegal_q;
        case (state_q)
            e_idle: begin
                if (req_v_i & ~flush_i) begin
                    op_d = req_op_i;
                    dp_d = req_dp_i;
                    rm_d = rm_res_s;
                    a_d  = req_a_i;
                    b_d  = req_b_i;
                    rd_d = req_rd_i;
                    if (rm_illegal(rm_res_s)) begin
                        state_d   = e_resp;
                        illegal_d = 1'b1;
                        data_d    = {dword_width_p{1'b0}};
                        fflags_d  = 5'b00000;
                    end else begin
                        state_d   = e_issue;
                        illegal_d = 1'b0;
                    end
                end else begin
                    state_d = e_idle;
                end
            end
            e_issue: begin
                if (unit_ready_i) begin
                    state_d = flush_i ? e_drain : e_wait;
                end else if (flush_i) begin
                    state_d = e_idle;
                end else begin
                    state_d = e_issue;
                end
            end
            e_wait: begin
                if (unit_v_i & flush_i) begin
                    state_d = e_idle;
                end else if (unit_v_i) begin
                    state_d  = e_resp;
                    data_d   = dp_q ? unit_data_i
                                    : {{(dword_width_p-32){1'b1}}, unit_data_i[31:0]};
                    fflags_d = unit_fflags_i;
                end else if (flush_i) begin
                    state_d = e_drain;
                end else begin
                    state_d = e_wait;
                end
            end
            e_resp: begin
                if (flush_i | resp_yumi_i) begin
                    state_d = e_idle;
                end else begin
                    state_d = e_resp;
                end
            end
            e_drain: begin
                if (unit_v_i) begin
                    state_d = e_idle;
                end else begin
                    state_d = e_drain;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    // Clear takes effect before the newly committed flags are OR'd in.
    always_comb begin
        acc_d = (fflags_clr_i ? 5'b00000 : acc_q) | (accum_s ? fflags_q : 5'b00000);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_idle;
            op_q      <= 1'b0;
            dp_q      <= 1'b0;
            rm_q      <= 3'b000;
            a_q       <= {dword_width_p{1'b0}};
            b_q       <= {dword_width_p{1'b0}};
            rd_q      <= {reg_addr_width_p{1'b0}};
            data_q    <= {dword_width_p{1'b0}};
            fflags_q  <= 5'b00000;
            illegal_q <= 1'b0;
            acc_q     <= 5'b00000;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dp_q      <= dp_d;
            rm_q      <= rm_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            fflags_q  <= fflags_d;
            illegal_q <= illegal_d;
            acc_q     <= acc_d;
        end
    end

    assign req_ready_o    = (state_q == e_idle);
    assign unit_v_o       = (state_q == e_issue);
    assign unit_op_o      = op_q;
    assign unit_dp_o      = dp_q;
    assign unit_rm_o      = rm_q;
    assign unit_a_o       = a_q;
    assign unit_b_o       = b_q;
    assign resp_v_o       = (state_q == e_resp);
    assign resp_data_o    = data_q;
    assign resp_rd_o      = rd_q;
    assign resp_fflags_o  = fflags_q;
    assign resp_illegal_o = illegal_q;
    assign fflags_acc_o   = acc_q;

endmodule

// File: doc/bp_be_fp_iter_ctrl.md
# bp_be_fp_iter_ctrl

Sequencer for the shared iterative FP divide/square-root unit in the backend FP pipe. Accepts one FDIV/FSQRT request at a time from the FP issue stage, resolves the RV64 rounding mode (including e_dyn against the CSR frm), launches the unit over a valid/ready handshake, and returns a NaN-boxed result with its fflags. It also keeps the sticky fflags accumulator that feeds the fcsr CSR, and supports pipeline flush mid-operation.

## Interface
- dword_width_p, 64: operand/result width (rv64_dword_width_gp)
- reg_addr_width_p, 5: destination register tag width

- clk_i  in  1  clock, rising edge
- reset_n_i  in  1  reset; asynchronous, active-low
- req_v_i  in  1  request valid
- req_ready_o  out  1  high iff state is IDLE
- req_op_i  in  1  0 = div, 1 = sqrt
- req_dp_i  in  1  1 = double, 0 = single
- req_rm_i  in  3  instruction rm field (rv64_frm_e encoding)
- req_a_i, req_b_i  in  64 each  operands (b ignored for sqrt)
- req_rd_i  in  5  destination tag
- frm_i  in  3  current CSR frm
- flush_i  in  1  kill in-flight operation
- unit_v_o  out  1  launch valid to iterative unit
- unit_ready_i  in  1  unit accepts launch
- unit_op_o, unit_dp_o  out  1 each  registered op/precision
- unit_rm_o  out  3  resolved rounding mode
- unit_a_o, unit_b_o  out  64 each  registered operands
- unit_v_i  in  1  one-cycle result pulse
- unit_data_i  in  64  result
- unit_fflags_i  in  5  {nv,dz,of,uf,nx}
- resp_v_o  out  1  response valid
- resp_yumi_i  in  1  consumer takes response (only when resp_v_o)
- resp_data_o  out  64  result
- resp_rd_o  out  5  destination tag
- resp_fflags_o  out  5  fflags of this op
- resp_illegal_o  out  1  illegal rounding mode; data/fflags zero
- fflags_clr_i  in  1  CSR write clearing the accumulator
- fflags_acc_o  out  5  sticky OR of committed fflags

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: req_v_i & req_ready_o latches op, dp, operands, rd, resolved rm. rm = frm_i if req_rm_i == e_dyn, else req_rm_i. If resolved rm is 3'b101, 3'b110 or 3'b111, go to RESP with resp_illegal_o=1 and no unit launch. Otherwise go to ISSUE.
- ISSUE: unit_v_o=1. unit_v_o & unit_ready_i -> WAIT.
- WAIT: unit_v_i captures the result. If dp=0, data = {32'hFFFF_FFFF, unit_data_i[31:0]} (NaN-box); else unit_data_i. Fflags are captured and the state goes to RESP.
- RESP: resp_v_o=1, outputs held stable. resp_yumi_i -> IDLE.
- DRAIN: waits for unit_v_i, discards the result, then goes to IDLE. resp_v_o stays 0.
- Flush, which has priority over every other transition in the same cycle:
  - IDLE: a coincident request handshake is dropped.
  - ISSUE with unit_ready_i=0: go to IDLE.
  - ISSUE with unit_ready_i=1: the launch has happened, so go to DRAIN.
  - WAIT without unit_v_i: go to DRAIN.
  - WAIT with unit_v_i: go to IDLE, result dropped.
  - RESP: go to IDLE; a coincident resp_yumi_i is ignored and flags are not accumulated.
  - DRAIN: no effect.
- Accumulator:
  - On resp_v_o & resp_yumi_i & ~flush_i & ~resp_illegal_o: acc |= resp_fflags_o.
  - fflags_clr_i alone: acc = 0.
  - fflags_clr_i together with an accumulate: acc = new flags only (clear first, then OR).

## Timing
- Reset (reset_n_i low, async): state IDLE, req_ready_o=1, and every other output 0, including fflags_acc_o.
- Request accepted in cycle 0 -> unit_v_o in cycle 1 at the earliest.
- unit_v_i in cycle N -> resp_v_o in cycle N+1.
- Illegal rm accepted in cycle 0 -> resp_v_o in cycle 1.
- After resp_yumi_i in cycle M, req_ready_o is high in M+1. There is no back-to-back bypass, so the minimum spacing between requests is 4 cycles with a 1-cycle unit.
- All unit_*_o and resp_*_o outputs are registers or decodes of state. The only combinational input-to-output path is req_ready_o from state.
- frm_i is sampled only in the acceptance cycle. Later changes do not affect an in-flight op.

## Test plan
- Double div, rm=e_rne, unit_ready_i high, unit returns data 64'h4000_0000_0000_0000 with fflags 5'b00001 three cycles after launch -> resp_v_o one cycle later with that data and rd, fflags 00001, illegal=0; fflags_acc_o=00001 after yumi.
- Single sqrt, req_rm_i=e_dyn, frm_i=e_rtz, unit result 64'h0000_0000_3F80_0000 -> unit_rm_o=3'b001; resp_data_o=64'hFFFF_FFFF_3F80_0000.
- req_rm_i=e_dyn with frm_i=3'b101, and separately req_rm_i=3'b110 -> unit_v_o never asserted; resp_v_o in cycle 1 with resp_illegal_o=1, data and fflags 0; accumulator unchanged after yumi.
- unit_ready_i held low 5 cycles -> unit_v_o and operands stable for 5 cycles; launch on cycle 6; single response.
- Flush in WAIT, then unit_v_i 2 cycles later -> state DRAIN, no resp_v_o, req_ready_o high the cycle after unit_v_i. Separately, flush coincident with resp_yumi_i -> accumulator unchanged.
- Accumulator = 5'b10000 and an accumulate of 00100 with fflags_clr_i in the same cycle -> acc=00100. Async reset asserted mid-WAIT -> all outputs 0 immediately, req_ready_o=1.
